us_arp_tx: RTL and testbench

//  ARP transmitter paired with the ARP receiver: builds ARP request/reply frames on a 64-bit AXI-Stream toward the 10G MAC TX mux.

---
 rtl/us_arp_tx_if.sv | 15 +
 rtl/us_arp_tx.sv | 197 +++++++++++++++++++
 tb/tb_us_arp_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/us_arp_tx_if.sv
// AXI-Stream transmit bus carrying ARP frames from the ARP transmitter to the MAC TX mux.
interface us_arp_tx_if;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tuser;
  logic              tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/us_arp_tx.sv
// ARP transmitter: snapshots a reply or request on accept and streams one 60-byte
// Ethernet/ARP frame (no FCS) as eight 64-bit AXI-Stream beats.
module us_arp_tx #(
  parameter int unsigned MIN_GAP = 2
) (
  input  logic         rx_axis_aclk,
  input  logic         rx_axis_aresetn,
  input  logic [47:0]  local_mac_addr,
  input  logic [31:0]  local_ip_addr,
  input  logic [31:0]  dst_ip_addr,
  input  logic         arp_request_req,
  output logic         arp_request_ack,
  input  logic         arp_reply_req,
  output logic         arp_reply_ack,
  input  logic [47:0]  recv_src_mac_addr,
  input  logic [31:0]  recv_src_ip_addr,
  us_arp_tx_if.master  tx_axis,
  output logic         arp_tx_busy
);
  localparam int unsigned MAC_W   = 48;
  localparam int unsigned IP_W    = 32;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned KEEP_W  = 8;
  localparam int unsigned BEAT_W  = 3;
  localparam int unsigned GAP_W   = 4;
  localparam int unsigned FRAME_W = 512;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(7);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);
  localparam logic [KEEP_W-1:0] KEEP_FULL = 8'hFF;
  localparam logic [KEEP_W-1:0] KEEP_TAIL = 8'h0F;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [MAC_W-1:0]    eth_dst_q, eth_dst_d;
  logic [MAC_W-1:0]    tha_q, tha_d;
  logic [IP_W-1:0]     tpa_q, tpa_d;
  logic [MAC_W-1:0]    lmac_q, lmac_d;
  logic [IP_W-1:0]     lip_q, lip_d;
  logic                is_reply_q, is_reply_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                req_ack_q, req_ack_d;
  logic                rep_ack_q, rep_ack_d;
  logic                busy_q, busy_d;
  logic                load_beat;
  logic [FRAME_W-1:0]  frame;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    eth_dst_d  = eth_dst_q;
    tha_d      = tha_q;
    tpa_d      = tpa_q;
    lmac_d     = lmac_q;
    lip_d      = lip_q;
    is_reply_d = is_reply_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    req_ack_d  = 1'b0;
    rep_ack_d  = 1'b0;
    load_beat  = 1'b0;
    frame      = '0;

    unique case (state_q)
      S_IDLE: begin
        // Reply wins a tie; the request line stays high and is taken next time round.
        if (arp_reply_req) begin
          eth_dst_d  = recv_src_mac_addr;
          tha_d      = recv_src_mac_addr;
          tpa_d      = recv_src_ip_addr;
          is_reply_d = 1'b1;
          rep_ack_d  = 1'b1;
        end else if (arp_request_req) begin
          eth_dst_d  = {MAC_W{1'b1}};
          tha_d      = '0;
          tpa_d      = dst_ip_addr;
          is_reply_d = 1'b0;
          req_ack_d  = 1'b1;
        end
        if (arp_reply_req || arp_request_req) begin
          lmac_d     = local_mac_addr;
          lip_d      = local_ip_addr;
          beat_cnt_d = '0;
          tvalid_d   = 1'b1;
          load_beat  = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (tvalid_q && tx_axis.tready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            tkeep_d   = '0;
            tdata_d   = '0;
            gap_cnt_d = '0;
            state_d   = (MIN_GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            load_beat  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Whole frame, byte n at frame[8n+:8], built from the snapshot being loaded.
    for (int i = 0; i < 6; i++) begin
      frame[8*i      +: 8] = eth_dst_d[MAC_W-1-8*i -: 8];
      frame[8*(6+i)  +: 8] = lmac_d[MAC_W-1-8*i -: 8];
      frame[8*(22+i) +: 8] = lmac_d[MAC_W-1-8*i -: 8];
      frame[8*(32+i) +: 8] = tha_d[MAC_W-1-8*i -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      frame[8*(28+i) +: 8] = lip_d[IP_W-1-8*i -: 8];
      frame[8*(38+i) +: 8] = tpa_d[IP_W-1-8*i -: 8];
    end
    frame[8*12 +: 8] = 8'h08;
    frame[8*13 +: 8] = 8'h06;
    frame[8*14 +: 8] = 8'h00;
    frame[8*15 +: 8] = 8'h01;
    frame[8*16 +: 8] = 8'h08;
    frame[8*17 +: 8] = 8'h00;
    frame[8*18 +: 8] = 8'h06;
    frame[8*19 +: 8] = 8'h04;
    frame[8*20 +: 8] = 8'h00;
    frame[8*21 +: 8] = is_reply_d ? 8'h02 : 8'h01;

    if (load_beat) begin
      tdata_d = frame[{beat_cnt_d, 6'd0} +: DATA_W];
      tkeep_d = (beat_cnt_d == LAST_BEAT) ? KEEP_TAIL : KEEP_FULL;
      tlast_d = (beat_cnt_d == LAST_BEAT);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      eth_dst_q  <= '0;
      tha_q      <= '0;
      tpa_q      <= '0;
      lmac_q     <= '0;
      lip_q      <= '0;
      is_reply_q <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      req_ack_q  <= 1'b0;
      rep_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      eth_dst_q  <= eth_dst_d;
      tha_q      <= tha_d;
      tpa_q      <= tpa_d;
      lmac_q     <= lmac_d;
      lip_q      <= lip_d;
      is_reply_q <= is_reply_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      req_ack_q  <= req_ack_d;
      rep_ack_q  <= rep_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_axis.tdata   = tdata_q;
  assign tx_axis.tkeep   = tkeep_q;
  assign tx_axis.tvalid  = tvalid_q;
  assign tx_axis.tlast   = tlast_q;
  assign tx_axis.tuser   = 1'b0;
  assign arp_request_ack = req_ack_q;
  assign arp_reply_ack   = rep_ack_q;
  assign arp_tx_busy     = busy_q;
endmodule

// File: tb/tb_us_arp_tx.sv
// Directed bench for us_arp_tx: frame contents, ack/priority, gap, backpressure, snapshot, reset.
module tb_us_arp_tx;
  localparam int unsigned MIN_GAP = 2;
  localparam logic [47:0] LMAC = 48'h000A_3501_0203;
  localparam logic [31:0] LIP  = 32'hC0A8_017B;
  localparam logic [31:0] DIP  = 32'hC0A8_0165;
  localparam logic [47:0] RMAC = 48'hA036_9F7D_E58C;
  localparam logic [31:0] RIP  = 32'hC0A8_0165;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] local_mac_addr, recv_src_mac_addr;
  logic [31:0] local_ip_addr, dst_ip_addr, recv_src_ip_addr;
  logic        arp_request_req, arp_request_ack, arp_reply_req, arp_reply_ack, arp_tx_busy;

  us_arp_tx_if tx_axis();

  us_arp_tx #(.MIN_GAP(MIN_GAP)) dut (
    .rx_axis_aclk      (clk),
    .rx_axis_aresetn   (rst_n),
    .local_mac_addr    (local_mac_addr),
    .local_ip_addr     (local_ip_addr),
    .dst_ip_addr       (dst_ip_addr),
    .arp_request_req   (arp_request_req),
    .arp_request_ack   (arp_request_ack),
    .arp_reply_req     (arp_reply_req),
    .arp_reply_ack     (arp_reply_ack),
    .recv_src_mac_addr (recv_src_mac_addr),
    .recv_src_ip_addr  (recv_src_ip_addr),
    .tx_axis           (tx_axis),
    .arp_tx_busy       (arp_tx_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [63:0] cap_data [8];
  logic [7:0]  cap_keep [8];
  logic        cap_last [8];
  logic [63:0] ref_data [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wire-order byte string: byte 0 at the MSB, padded to 64 bytes.
  function automatic logic [511:0] mk_frame(input bit rep, input logic [47:0] dmac,
                                            input logic [31:0] tpa);
    return {rep ? dmac : 48'hFFFF_FFFF_FFFF, LMAC, 16'h0806, 16'h0001, 16'h0800,
            8'h06, 8'h04, rep ? 16'h0002 : 16'h0001, LMAC, LIP,
            rep ? dmac : 48'h0, tpa, 176'h0};
  endfunction

  function automatic logic [63:0] exp_beat(input logic [511:0] frm, input int b);
    logic [63:0] v;
    v = '0;
    for (int n = 0; n < 8; n++) v[8*n +: 8] = frm[511 - 8*(8*b + n) -: 8];
    return v;
  endfunction

  task automatic accept(input string tag, input bit rep);
    tick();
    chk({tag, "_rep_ack"}, 64'(arp_reply_ack), 64'(rep));
    chk({tag, "_req_ack"}, 64'(arp_request_ack), 64'(!rep));
    chk({tag, "_tvalid_lat1"}, 64'(tx_axis.tvalid), 64'd1);
    chk({tag, "_busy"}, 64'(arp_tx_busy), 64'd1);
  endtask

  task automatic run_frame(input string tag, input logic [511:0] frm, input bit rnd,
                           input int chg_at, input int stop_at);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < stop_at && cyc < 400) begin
      if (got == chg_at) begin
        recv_src_mac_addr = 48'h1122_3344_5566;
        recv_src_ip_addr  = 32'h0A0B_0C0D;
        dst_ip_addr       = 32'h0A0B_0C0E;
      end
      tx_axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc > 0) chk({tag, "_ack_quiet"}, 64'({arp_request_ack, arp_reply_ack}), 64'd0);
      if (got > 0) chk({tag, "_valid_hold"}, 64'(tx_axis.tvalid), 64'd1);
      if (tx_axis.tvalid) begin
        chk({tag, "_tdata"}, tx_axis.tdata, exp_beat(frm, got));
        chk({tag, "_tkeep"}, 64'(tx_axis.tkeep), (got == 7) ? 64'h0F : 64'hFF);
        chk({tag, "_tlast"}, 64'(tx_axis.tlast), 64'(got == 7));
        chk({tag, "_tuser"}, 64'(tx_axis.tuser), 64'd0);
        if (tx_axis.tready) begin
          cap_data[got] = tx_axis.tdata;
          cap_keep[got] = tx_axis.tkeep;
          cap_last[got] = tx_axis.tlast;
          got++;
        end
      end
      tick();
      cyc++;
    end
    chk({tag, "_beats"}, 64'(got), 64'(stop_at));
    if (stop_at == 8) begin
      chk({tag, "_tvalid_after"}, 64'(tx_axis.tvalid), 64'd0);
      chk({tag, "_tlast_after"}, 64'(tx_axis.tlast), 64'd0);
    end
    tx_axis.tready = 1'b1;
  endtask

  initial begin
    int n;
    local_mac_addr    = LMAC;
    local_ip_addr     = LIP;
    dst_ip_addr       = DIP;
    recv_src_mac_addr = RMAC;
    recv_src_ip_addr  = RIP;
    arp_request_req   = 1'b0;
    arp_reply_req     = 1'b0;
    tx_axis.tready    = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_tvalid", 64'(tx_axis.tvalid), 64'd0);
    chk("rst_tdata", tx_axis.tdata, 64'd0);
    chk("rst_tkeep", 64'(tx_axis.tkeep), 64'd0);
    chk("rst_tlast", 64'(tx_axis.tlast), 64'd0);
    chk("rst_acks", 64'({arp_request_ack, arp_reply_ack}), 64'd0);
    chk("rst_busy", 64'(arp_tx_busy), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: request, full readiness
    arp_request_req = 1'b1;
    accept("t1", 1'b0);
    arp_request_req = 1'b0;
    run_frame("t1", mk_frame(1'b0, 48'h0, DIP), 1'b0, -1, 8);
    chk("t1_beat0", cap_data[0], 64'h0A00_FFFF_FFFF_FFFF);
    chk("t1_beat2", cap_data[2], 64'h0A00_0100_0406_0008);
    chk("t1_beat3", cap_data[3], 64'h7B01_A8C0_0302_0135);
    chk("t1_beat4", cap_data[4], 64'hA8C0_0000_0000_0000);
    chk("t1_beat5", cap_data[5], 64'h0000_0000_0000_6501);
    chk("t1_beat7", cap_data[7], 64'h0);
    chk("t1_keep7", 64'(cap_keep[7]), 64'h0F);
    chk("t1_last7", 64'(cap_last[7]), 64'd1);
    chk("t1_last6", 64'(cap_last[6]), 64'd0);
    for (int i = 0; i < 8; i++) ref_data[i] = cap_data[i];
    repeat (5) tick();
    chk("t1_idle_busy", 64'(arp_tx_busy), 64'd0);

    // 2: reply
    arp_reply_req = 1'b1;
    accept("t2", 1'b1);
    arp_reply_req = 1'b0;
    run_frame("t2", mk_frame(1'b1, RMAC, RIP), 1'b0, -1, 8);
    chk("t2_beat0", cap_data[0], 64'h0A00_8CE5_7D9F_36A0);
    chk("t2_beat2", cap_data[2], 64'h0A00_0200_0406_0008);
    chk("t2_beat4", cap_data[4], 64'hA8C0_8CE5_7D9F_36A0);
    chk("t2_beat5", cap_data[5], 64'h0000_0000_0000_6501);
    repeat (5) tick();

    // 3: simultaneous request and reply
    arp_reply_req   = 1'b1;
    arp_request_req = 1'b1;
    accept("t3", 1'b1);
    arp_reply_req = 1'b0;
    run_frame("t3rep", mk_frame(1'b1, RMAC, RIP), 1'b0, -1, 8);
    n = 0;
    while (!tx_axis.tvalid && n < 20) begin
      chk("t3_gap_no_ack", 64'(arp_request_ack), 64'd0);
      n++;
      tick();
    end
    chk("t3_gap_len", 64'(n >= int'(MIN_GAP) && n <= int'(MIN_GAP) + 1), 64'd1);
    chk("t3_req_ack", 64'(arp_request_ack), 64'd1);
    chk("t3_rep_ack", 64'(arp_reply_ack), 64'd0);
    arp_request_req = 1'b0;
    run_frame("t3req", mk_frame(1'b0, 48'h0, DIP), 1'b0, -1, 8);
    repeat (5) tick();

    // 4: random backpressure
    arp_request_req = 1'b1;
    accept("t4", 1'b0);
    arp_request_req = 1'b0;
    run_frame("t4", mk_frame(1'b0, 48'h0, DIP), 1'b1, -1, 8);
    for (int i = 0; i < 8; i++) chk("t4_vs_t1", cap_data[i], ref_data[i]);
    repeat (5) tick();

    // 5: inputs change mid-frame
    arp_reply_req = 1'b1;
    accept("t5", 1'b1);
    arp_reply_req = 1'b0;
    run_frame("t5", mk_frame(1'b1, RMAC, RIP), 1'b0, 3, 8);
    recv_src_mac_addr = RMAC;
    recv_src_ip_addr  = RIP;
    dst_ip_addr       = DIP;
    repeat (5) tick();

    // 6: reset during beat 4, request still pending
    arp_request_req = 1'b1;
    accept("t6", 1'b0);
    run_frame("t6a", mk_frame(1'b0, 48'h0, DIP), 1'b0, -1, 4);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", 64'(tx_axis.tvalid), 64'd0);
    chk("t6_rst_tlast", 64'(tx_axis.tlast), 64'd0);
    chk("t6_rst_busy", 64'(arp_tx_busy), 64'd0);
    rst_n = 1'b1;
    accept("t6b", 1'b0);
    arp_request_req = 1'b0;
    run_frame("t6b", mk_frame(1'b0, 48'h0, DIP), 1'b0, -1, 8);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
